// File: rtl/urv_dbg_mbx_host_if.sv
// Transport-side handshake bundle for the uRV debug mailbox host endpoint.
// Signal names keep the endpoint's own port naming so both sides read the same.
`timescale 1ns/1ps
interface urv_dbg_mbx_host_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [30:0] req_data_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [29:0] rsp_data_o;
  logic        rsp_timeout_o;
  logic        rsp_error_o;

  modport slave (
    input  req_valid_i, req_data_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_timeout_o, rsp_error_o
  );

  modport master (
    output req_valid_i, req_data_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_timeout_o, rsp_error_o
  );
endinterface

// File: rtl/urv_dbg_mbx_host.sv
// Host endpoint of the uRV debug mailbox: posts a request word, verifies it landed,
// waits for the firmware reply (or timeout), clears the mailbox and hands back the result.
`timescale 1ns/1ps
module urv_dbg_mbx_host #(
  parameter int unsigned g_timeout_cycles = 65536,
  parameter int unsigned g_max_retries    = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  urv_dbg_mbx_host_if.slave        tr,
  output logic [31:0]              mbx_data_o,
  output logic                     mbx_write_o,
  input  logic [31:0]              mbx_data_i
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_POST     = 3'd1;
  localparam logic [2:0] ST_CHECK    = 3'd2;
  localparam logic [2:0] ST_WAIT_RSP = 3'd3;
  localparam logic [2:0] ST_CLEAR    = 3'd4;
  localparam logic [2:0] ST_CLR_CHK  = 3'd5;
  localparam logic [2:0] ST_DELIVER  = 3'd6;

  localparam int unsigned TO_W = (g_timeout_cycles > 1) ? $clog2(g_timeout_cycles) : 1;
  localparam int unsigned RT_W = (g_max_retries > 0) ? $clog2(g_max_retries + 1) : 1;
  localparam bit              TO_EN   = (g_timeout_cycles != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((g_timeout_cycles == 0) ? 0 : g_timeout_cycles - 1);
  localparam logic [RT_W-1:0] RT_MAX  = RT_W'(g_max_retries);

  logic [2:0]      state;
  logic [31:0]     post_word;
  logic [TO_W-1:0] to_cnt;
  logic [RT_W-1:0] retry;
  logic            rsp_valid;
  logic            rsp_timeout;
  logic            rsp_error;
  logic [29:0]     rsp_data;
  logic            fw_replied;

  // Firmware marks its reply with RSP set and REQ clear.
  assign fw_replied = (mbx_data_i[31:30] == 2'b01);

  assign tr.req_ready_o   = (state == ST_IDLE);
  assign tr.rsp_valid_o   = rsp_valid;
  assign tr.rsp_timeout_o = rsp_timeout;
  assign tr.rsp_error_o   = rsp_error;
  assign tr.rsp_data_o    = rsp_data;

  // The write strobe is a pure function of state so reset drops it without a clock edge.
  assign mbx_write_o = (state == ST_POST) || (state == ST_CLEAR);
  assign mbx_data_o  = (state == ST_POST) ? post_word : 32'h0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      post_word   <= 32'h0;
      to_cnt      <= '0;
      retry       <= '0;
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_error   <= 1'b0;
      rsp_data    <= 30'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tr.req_valid_i) begin
            post_word <= {1'b1, tr.req_data_i};
            retry     <= '0;
            rsp_data  <= 30'h0;
            state     <= ST_POST;
          end
        end
        ST_POST: state <= ST_CHECK;
        ST_CHECK: begin
          // A same-cycle firmware CSR write beats our post; re-post or give up.
          if (mbx_data_i == post_word) begin
            to_cnt <= '0;
            state  <= ST_WAIT_RSP;
          end else if (fw_replied) begin
            rsp_data <= mbx_data_i[29:0];
            retry    <= '0;
            state    <= ST_CLEAR;
          end else if (retry < RT_MAX) begin
            retry <= retry + 1'b1;
            state <= ST_POST;
          end else begin
            rsp_error <= 1'b1;
            retry     <= '0;
            state     <= ST_CLEAR;
          end
        end
        ST_WAIT_RSP: begin
          to_cnt <= to_cnt + 1'b1;
          if (fw_replied) begin
            rsp_data <= mbx_data_i[29:0];
            retry    <= '0;
            state    <= ST_CLEAR;
          end else if (TO_EN && (to_cnt == TO_LAST)) begin
            rsp_timeout <= 1'b1;
            rsp_data    <= 30'h0;
            retry       <= '0;
            state       <= ST_CLEAR;
          end
        end
        ST_CLEAR: state <= ST_CLR_CHK;
        ST_CLR_CHK: begin
          if (mbx_data_i == 32'h0) begin
            rsp_valid <= 1'b1;
            state     <= ST_DELIVER;
          end else if (retry < RT_MAX) begin
            retry <= retry + 1'b1;
            state <= ST_CLEAR;
          end else begin
            rsp_error <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= ST_DELIVER;
          end
        end
        ST_DELIVER: begin
          if (tr.rsp_ready_i) begin
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_error   <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_urv_dbg_mbx_host.sv
// Directed bench for urv_dbg_mbx_host: a behavioural core mailbox with firmware
// reply/collision injection, driven from a table of hand-computed transactions.
`timescale 1ns/1ps
module tb_urv_dbg_mbx_host;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mbx_data_o;
  logic        mbx_write_o;
  logic [31:0] mbx_q = 32'h0;

  always #5 clk = ~clk;

  urv_dbg_mbx_host_if tif();

  urv_dbg_mbx_host #(
    .g_timeout_cycles(16),
    .g_max_retries   (3)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .tr         (tif),
    .mbx_data_o (mbx_data_o),
    .mbx_write_o(mbx_write_o),
    .mbx_data_i (mbx_q)
  );

  // Firmware-side controls, set by the stimulus process.
  int          fw_delay   = -1;
  logic [31:0] fw_word    = 32'h0;
  int          coll_posts = 0;
  logic [31:0] coll_word  = 32'h0;
  int          clr_coll   = 0;
  bit          clr_stats  = 1'b0;

  // Observations collected by the mailbox model.
  int          cyc = 0;
  int          post_cnt = 0;
  int          clear_cnt = 0;
  int          first_post_cyc = 0;
  logic [31:0] last_post_word = 32'h0;

  int n_chk  = 0;
  int n_fail = 0;

  // Core mailbox register: firmware writes win over host writes in the same cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clr_stats) begin
      post_cnt  <= 0;
      clear_cnt <= 0;
      first_post_cyc <= 0;
      mbx_q <= 32'h0;
    end else begin
      if (mbx_write_o && mbx_data_o != 32'h0) begin
        post_cnt <= post_cnt + 1;
        if (post_cnt == 0) first_post_cyc <= cyc;
        last_post_word <= mbx_data_o;
      end
      if (mbx_write_o && mbx_data_o == 32'h0) clear_cnt <= clear_cnt + 1;
      if (mbx_write_o && mbx_data_o != 32'h0 && post_cnt < coll_posts)
        mbx_q <= coll_word;
      else if (mbx_write_o && mbx_data_o == 32'h0 && clear_cnt < clr_coll)
        mbx_q <= 32'h0000_0002;
      else if (fw_delay > 0 && post_cnt > 0 && cyc == first_post_cyc + fw_delay)
        mbx_q <= fw_word;
      else if (mbx_write_o)
        mbx_q <= mbx_data_o;
    end
  end

  typedef struct {
    string       name;
    logic [30:0] req;
    logic [31:0] exp_word;
    int          fw_delay;
    logic [31:0] fw_word;
    int          coll_posts;
    logic [31:0] coll_word;
    int          clr_coll;
    int          hold;
    int          exp_lat;
    int          exp_posts;
    int          exp_clears;
    logic [29:0] exp_data;
    logic        exp_to;
    logic        exp_err;
    logic [31:0] exp_mbx;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit seen;
    int lat;
    @(negedge clk);
    fw_delay   = v.fw_delay;
    fw_word    = v.fw_word;
    coll_posts = v.coll_posts;
    coll_word  = v.coll_word;
    clr_coll   = v.clr_coll;
    clr_stats  = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    chk({v.name, " req_ready idle"}, 32'(tif.req_ready_o), 32'd1);
    tif.req_valid_i = 1'b1;
    tif.req_data_i  = v.req;
    @(negedge clk);
    tif.req_valid_i = 1'b0;
    chk({v.name, " req_ready busy"}, 32'(tif.req_ready_o), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (tif.rsp_valid_o) seen = 1'b1;
      else @(negedge clk);
    end
    chk({v.name, " rsp_valid seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    lat = cyc - first_post_cyc;
    chk({v.name, " latency"},    32'(lat),              32'(v.exp_lat));
    chk({v.name, " posts"},      32'(post_cnt),         32'(v.exp_posts));
    chk({v.name, " clears"},     32'(clear_cnt),        32'(v.exp_clears));
    chk({v.name, " post word"},  last_post_word,        v.exp_word);
    chk({v.name, " rsp_data"},   32'(tif.rsp_data_o),   32'(v.exp_data));
    chk({v.name, " timeout"},    32'(tif.rsp_timeout_o), 32'(v.exp_to));
    chk({v.name, " error"},      32'(tif.rsp_error_o),  32'(v.exp_err));
    chk({v.name, " mailbox"},    mbx_q,                 v.exp_mbx);
    for (int i = 0; i < v.hold; i++) begin
      if (i == 3) begin
        tif.req_valid_i = 1'b1;
        tif.req_data_i  = 31'h7FFF_FFFF;
      end
      if (i == 5) tif.req_valid_i = 1'b0;
      @(negedge clk);
      chk({v.name, " hold valid"},     32'(tif.rsp_valid_o), 32'd1);
      chk({v.name, " hold data"},      32'(tif.rsp_data_o),  32'(v.exp_data));
      chk({v.name, " hold req_ready"}, 32'(tif.req_ready_o), 32'd0);
    end
    tif.req_valid_i = 1'b0;
    tif.rsp_ready_i = 1'b1;
    @(negedge clk);
    tif.rsp_ready_i = 1'b0;
    chk({v.name, " valid dropped"},   32'(tif.rsp_valid_o),   32'd0);
    chk({v.name, " timeout dropped"}, 32'(tif.rsp_timeout_o), 32'd0);
    chk({v.name, " error dropped"},   32'(tif.rsp_error_o),   32'd0);
    chk({v.name, " req_ready back"},  32'(tif.req_ready_o),   32'd1);
    chk({v.name, " no extra post"},   32'(post_cnt),          32'(v.exp_posts));
  endtask

  initial begin
    tif.req_valid_i = 1'b0;
    tif.req_data_i  = 31'h0;
    tif.rsp_ready_i = 1'b0;

    //          name           req           post word     dly fw word       cp cw            cc hold lat posts clears data          to    err   mbx
    vecs[0]  = '{"basic",     31'h1234_5678, 32'h9234_5678, 10, 32'h4000_00AB, 0, 32'h0,         0, 0,  14, 1, 1, 30'h0AB,       1'b0, 1'b0, 32'h0};
    vecs[1]  = '{"timeout",   31'h0000_0001, 32'h8000_0001, -1, 32'h0,         0, 32'h0,         0, 0,  20, 1, 1, 30'h0,         1'b1, 1'b0, 32'h0};
    vecs[2]  = '{"race",      31'h7FFF_FFFF, 32'hFFFF_FFFF, 16, 32'h7FFF_FFFF, 0, 32'h0,         0, 0,  20, 1, 1, 30'h3FFF_FFFF, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{"late rsp",  31'h0000_0ABC, 32'h8000_0ABC, 17, 32'h4000_1111, 0, 32'h0,         0, 0,  20, 1, 1, 30'h0,         1'b1, 1'b0, 32'h0};
    vecs[4]  = '{"min lat",   31'h4000_0000, 32'hC000_0000,  1, 32'h4000_0001, 0, 32'h0,         0, 0,   5, 1, 1, 30'h1,         1'b0, 1'b0, 32'h0};
    vecs[5]  = '{"coll once", 31'h0555_AAAA, 32'h8555_AAAA,  6, 32'h4000_0042, 1, 32'h0000_0001, 0, 0,  10, 2, 1, 30'h42,        1'b0, 1'b0, 32'h0};
    vecs[6]  = '{"coll all",  31'h0000_00FF, 32'h8000_00FF, -1, 32'h0,         4, 32'h0000_0001, 0, 0,  10, 4, 1, 30'h0,         1'b0, 1'b1, 32'h0};
    vecs[7]  = '{"early rsp", 31'h0000_0100, 32'h8000_0100, -1, 32'h0,         1, 32'h4000_0055, 0, 0,   4, 1, 1, 30'h55,        1'b0, 1'b0, 32'h0};
    vecs[8]  = '{"clr once",  31'h0000_0200, 32'h8000_0200,  1, 32'h4000_0003, 0, 32'h0,         1, 0,   7, 1, 2, 30'h3,         1'b0, 1'b0, 32'h0};
    vecs[9]  = '{"clr all",   31'h0000_0300, 32'h8000_0300,  1, 32'h4000_0004, 0, 32'h0,         4, 0,  11, 1, 4, 30'h4,         1'b0, 1'b1, 32'h0000_0002};
    vecs[10] = '{"backpress", 31'h0000_0400, 32'h8000_0400,  2, 32'h4000_0777, 0, 32'h0,         0, 20,  6, 1, 1, 30'h777,       1'b0, 1'b0, 32'h0};

    #1;
    chk("reset req_ready",   32'(tif.req_ready_o),   32'd1);
    chk("reset rsp_valid",   32'(tif.rsp_valid_o),   32'd0);
    chk("reset rsp_data",    32'(tif.rsp_data_o),    32'd0);
    chk("reset rsp_timeout", 32'(tif.rsp_timeout_o), 32'd0);
    chk("reset rsp_error",   32'(tif.rsp_error_o),   32'd0);
    chk("reset mbx_write",   32'(mbx_write_o),       32'd0);
    chk("reset mbx_data",    mbx_data_o,             32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 11; k++) run_vec(vecs[k]);

    // Asynchronous reset while waiting for the firmware reply.
    @(negedge clk);
    fw_delay   = -1;
    coll_posts = 0;
    clr_coll   = 0;
    clr_stats  = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    tif.req_valid_i = 1'b1;
    tif.req_data_i  = 31'h0000_0500;
    @(negedge clk);
    tif.req_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid-txn req_ready", 32'(tif.req_ready_o), 32'd0);
    chk("mid-txn mailbox",   mbx_q,                32'h8000_0500);
    #2 rst_n = 1'b0;
    #1;
    chk("async req_ready",   32'(tif.req_ready_o),   32'd1);
    chk("async rsp_valid",   32'(tif.rsp_valid_o),   32'd0);
    chk("async rsp_timeout", 32'(tif.rsp_timeout_o), 32'd0);
    chk("async mbx_write",   32'(mbx_write_o),       32'd0);
    chk("async mbx_data",    mbx_data_o,             32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
